// File: rtl/mult_pkg.sv
// Shared definitions for the two-requester multiplier arbiter: FSM state
// encodings and the default operand width.
package mult_pkg;

  localparam int unsigned MULT_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. 'last' is the requester served most recently;
// on a tie the other requester wins. Output is one-hot (or zero).
module rr_arb2
  import mult_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Favour requester 0 on a tie only when requester 1 was served last
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last)) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one sequential multiplier between two requesters.
// FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Optional feature: define MULT_ARB_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT_CYC cycles; on expiry a zero product is returned with timeout_err.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int WIDTH       = MULT_WIDTH,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic [1:0]         gnt,
  output logic [1:0]         rsp_valid,
  output logic [2*WIDTH-1:0] rsp_prod,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_prod,
  output logic               busy
`ifdef MULT_ARB_TIMEOUT_EN
  ,
  output logic               timeout_err
`endif
);

  arb_state_t state;
  arb_state_t state_nxt;

  logic [1:0] pick;       // round-robin choice among current requests
  logic       owner;      // requester being served
  logic       last;       // requester served most recently
  logic       done_low;   // mul_done seen low since entering WAIT
  logic       done_hit;   // valid completion sampled this cycle
  logic       to_hit;     // WAIT budget exhausted this cycle
  logic [1:0] owner_oh;

  rr_arb2 u_rr (
    .req  (req),
    .last (last),
    .gnt  (pick)
  );

  assign owner_oh = owner ? 2'b10 : 2'b01;

  // The done level is stale right after ISSUE; only trust a high after a low
  assign done_hit = (state == S_WAIT) && done_low && mul_done;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             to_flag;

  assign to_hit      = (state == S_WAIT) && !done_hit &&
                       (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign timeout_err = (state == S_RESP) && to_flag;

  // Count WAIT cycles; cleared whenever the FSM is outside WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == S_WAIT) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  // Remember that the coming RESP is a timeout rather than a real result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_flag <= 1'b0;
    end else if (to_hit) begin
      to_flag <= 1'b1;
    end else if (state == S_RESP) begin
      to_flag <= 1'b0;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-state output decode
  always_comb begin
    state_nxt = state;
    gnt       = 2'b00;
    rsp_valid = 2'b00;
    mul_start = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (|req) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        gnt       = owner_oh;
        mul_start = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (done_hit || to_hit) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = owner_oh;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Capture owner and its operands when a request is accepted in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= 1'b0;
      mul_a <= '0;
      mul_b <= '0;
    end else if ((state == S_IDLE) && (|req)) begin
      owner <= pick[1];
      mul_a <= pick[1] ? a1 : a0;
      mul_b <= pick[1] ? b1 : b0;
    end
  end

  // Track whether mul_done has dropped since the start pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_low <= 1'b0;
    end else if (state == S_ISSUE) begin
      done_low <= 1'b0;
    end else if ((state == S_WAIT) && !mul_done) begin
      done_low <= 1'b1;
    end
  end

  // Result register: loads on completion or timeout, otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_prod <= '0;
    end else if (done_hit) begin
      rsp_prod <= mul_prod;
    end else if (to_hit) begin
      rsp_prod <= '0;
    end
  end

  // Round-robin pointer moves to the owner once its response goes out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (state == S_RESP) begin
      last <= owner;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: stimulus pushes expected grants and
// responses into queues, a monitor pops and compares on DUT strobes, and a
// small behavioural multiplier answers mul_start.
module tb_mult_arbiter;

  localparam int W = 16;

  typedef struct {
    logic [1:0]   g;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } gexp_t;

  typedef struct {
    logic [1:0]     v;
    logic [2*W-1:0] p;
    int             lat;
    bit             to;
  } rexp_t;

  logic           clk;
  logic           rst_n;
  logic [1:0]     req;
  logic [W-1:0]   a0, b0, a1, b1;
  logic [1:0]     gnt;
  logic [1:0]     rsp_valid;
  logic [2*W-1:0] rsp_prod;
  logic           mul_start;
  logic [W-1:0]   mul_a, mul_b;
  logic           mul_done;
  logic [2*W-1:0] mul_prod;
  logic           busy;
`ifdef MULT_ARB_TIMEOUT_EN
  logic           timeout_err;
`endif

  gexp_t gq[$];
  rexp_t rq[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int gnt_cyc = 0;

  // multiplier model controls
  int stale   = 0;
  int low_cyc = 2;
  bit stuck   = 0;

  mult_arbiter #(.WIDTH(W), .TIMEOUT_CYC(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_prod  (rsp_prod),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_done  (mul_done),
    .mul_prod  (mul_prod),
    .busy      (busy)
`ifdef MULT_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_g(input logic [1:0] g, input logic [W-1:0] a, input logic [W-1:0] b);
    gexp_t e;
    e.g = g; e.a = a; e.b = b;
    gq.push_back(e);
  endtask

  task automatic exp_r(input logic [1:0] v, input logic [2*W-1:0] p, input int lat, input bit to);
    rexp_t e;
    e.v = v; e.p = p; e.lat = lat; e.to = to;
    rq.push_back(e);
  endtask

  // Wait (bounded) for gnt[idx]; n returns cycles waited
  task automatic wait_gnt(input int idx, output int n);
    n = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (gnt[idx]) break;
    end
    if (!gnt[idx]) begin
      chk($sformatf("gnt%0d_arrival", idx), 64'(gnt), 64'(2'b01 << idx));
    end
  endtask

  // Wait (bounded) for all expected traffic to be consumed and the DUT idle
  task automatic drain(input string name);
    for (int k = 0; k < 200; k++) begin
      if (rq.size() == 0 && gq.size() == 0 && !busy) break;
      @(posedge clk);
      #1;
    end
    chk({name, "_rq_left"}, 64'(rq.size()), 64'd0);
    chk({name, "_gq_left"}, 64'(gq.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Behavioural sequential multiplier
  initial begin
    logic [2*W-1:0] p;
    mul_done = 1'b1;
    mul_prod = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mul_start === 1'b1) begin
        p = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
        repeat (1 + stale) @(posedge clk);
        #1;
        mul_done = 1'b0;
        if (stuck) begin
          for (int k = 0; k < 300; k++) begin
            if (!busy) break;
            @(posedge clk);
            #1;
          end
          mul_done = 1'b1;
        end else begin
          repeat (low_cyc) @(posedge clk);
          #1;
          mul_done = 1'b1;
          mul_prod = p;
        end
      end
    end
  end

  // Monitor: compare every grant and response against the queues
  initial begin
    gexp_t ge;
    rexp_t re;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (gnt !== 2'b00) begin
          if (gq.size() == 0) begin
            chk("unexpected_gnt", 64'(gnt), 64'd0);
          end else begin
            ge = gq.pop_front();
            chk("gnt", 64'(gnt), 64'(ge.g));
            chk("mul_start", 64'(mul_start), 64'd1);
            chk("mul_a", 64'(mul_a), 64'(ge.a));
            chk("mul_b", 64'(mul_b), 64'(ge.b));
          end
          gnt_cyc = cyc;
        end
        if (rsp_valid !== 2'b00) begin
          if (rq.size() == 0) begin
            chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
          end else begin
            re = rq.pop_front();
            chk("rsp_valid", 64'(rsp_valid), 64'(re.v));
            chk("rsp_prod", 64'(rsp_prod), 64'(re.p));
            chk("rsp_latency", 64'(cyc - gnt_cyc), 64'(re.lat));
`ifdef MULT_ARB_TIMEOUT_EN
            chk("timeout_err", 64'(timeout_err), 64'(re.to));
`endif
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    int n;
    rst_n = 1'b0;
    req = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_prod", 64'(rsp_prod), 64'd0);
    chk("rst_mul_start", 64'(mul_start), 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_mul_b", 64'(mul_b), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Tie after reset: 0 first, then 1
    a0 = 16'd7;  b0 = 16'd9;  a1 = 16'd11; b1 = 16'd13;
    exp_g(2'b01, 16'd7, 16'd9);
    exp_g(2'b10, 16'd11, 16'd13);
    exp_r(2'b01, 32'd63, 4, 1'b0);
    exp_r(2'b10, 32'd143, 4, 1'b0);
    req = 2'b11;
    wait_gnt(0, n);
    chk("tie_first_latency", 64'(n), 64'd1);
    req[0] = 1'b0;
    wait_gnt(1, n);
    req[1] = 1'b0;
    drain("tie1");

    // Repeated tie: 0 again
    a0 = 16'd2; b0 = 16'd4; a1 = 16'd6; b1 = 16'd5;
    exp_g(2'b01, 16'd2, 16'd4);
    exp_g(2'b10, 16'd6, 16'd5);
    exp_r(2'b01, 32'd8, 4, 1'b0);
    exp_r(2'b10, 32'd30, 4, 1'b0);
    req = 2'b11;
    wait_gnt(0, n);
    req[0] = 1'b0;
    wait_gnt(1, n);
    req[1] = 1'b0;
    drain("tie2");

    // Single request 3*5
    a0 = 16'd3; b0 = 16'd5;
    exp_g(2'b01, 16'd3, 16'd5);
    exp_r(2'b01, 32'd15, 4, 1'b0);
    req = 2'b01;
    wait_gnt(0, n);
    chk("single_latency", 64'(n), 64'd1);
    req = 2'b00;
    drain("single");
    repeat (3) @(posedge clk);
    #1;
    chk("rsp_prod_hold", 64'(rsp_prod), 64'd15);

    // Stale done: high for ISSUE + 2 WAIT cycles, low 16, then high
    stale = 2; low_cyc = 16;
    a0 = 16'd100; b0 = 16'd200;
    exp_g(2'b01, 16'd100, 16'd200);
    exp_r(2'b01, 32'd20000, 20, 1'b0);
    req = 2'b01;
    wait_gnt(0, n);
    req = 2'b00;
    drain("stale");
    stale = 0; low_cyc = 2;

    // Max operands on requester 1
    a1 = 16'hFFFF; b1 = 16'hFFFF;
    exp_g(2'b10, 16'hFFFF, 16'hFFFF);
    exp_r(2'b10, 32'hFFFE0001, 4, 1'b0);
    req = 2'b10;
    wait_gnt(1, n);
    req = 2'b00;
    drain("maxop");

    // Reset in the middle of WAIT: no response may appear
    low_cyc = 4;
    a0 = 16'd21; b0 = 16'd2;
    exp_g(2'b01, 16'd21, 16'd2);
    req = 2'b01;
    wait_gnt(0, n);
    req = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("midwait_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_gnt", 64'(gnt), 64'd0);
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst_rsp_prod", 64'(rsp_prod), 64'd0);
    chk("arst_mul_start", 64'(mul_start), 64'd0);
    chk("arst_mul_a", 64'(mul_a), 64'd0);
    chk("arst_mul_b", 64'(mul_b), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    drain("midwait");
    low_cyc = 2;

    // Tie after that reset goes to requester 0
    a0 = 16'd1; b0 = 16'd1; a1 = 16'd2; b1 = 16'd2;
    exp_g(2'b01, 16'd1, 16'd1);
    exp_g(2'b10, 16'd2, 16'd2);
    exp_r(2'b01, 32'd1, 4, 1'b0);
    exp_r(2'b10, 32'd4, 4, 1'b0);
    req = 2'b11;
    wait_gnt(0, n);
    req[0] = 1'b0;
    wait_gnt(1, n);
    req[1] = 1'b0;
    drain("tie3");

    // mul_done stuck low
    stuck = 1'b1;
    a0 = 16'd9; b0 = 16'd9;
    exp_g(2'b01, 16'd9, 16'd9);
`ifdef MULT_ARB_TIMEOUT_EN
    exp_r(2'b01, 32'd0, 9, 1'b1);
    req = 2'b01;
    wait_gnt(0, n);
    req = 2'b00;
    drain("timeout");
    chk("timeout_prod_hold", 64'(rsp_prod), 64'd0);
`else
    req = 2'b01;
    wait_gnt(0, n);
    req = 2'b00;
    repeat (40) @(posedge clk);
    #1;
    chk("stuck_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("stuck_recover_busy", 64'(busy), 64'd0);
    drain("stuck");
`endif
    repeat (3) @(posedge clk);
    #1;
    stuck = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
